// File: rtl/apb_slave_pkg.sv
// Shared widths, FSM state type and address decode for the APB completer memory.
package apb_slave_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_slv_state_t;

  // True when paddr is word aligned and lies in [base, base + depth*4).
  function automatic logic addr_ok(
    input logic [APB_ADDR_W-1:0] paddr,
    input logic [APB_ADDR_W-1:0] base,
    input int unsigned           depth
  );
    logic [APB_ADDR_W-1:0] offset;
    logic [APB_ADDR_W+1:0] span;
    offset = paddr - base;
    span   = (APB_ADDR_W + 2)'(depth) << 2;
    return (paddr[1:0] == 2'b00) && (paddr >= base) && ({2'b00, offset} < span);
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x 32 flop array: synchronous clear, one write port, one combinational read port.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned IW    = $clog2(DEPTH)
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  we,
  input  logic [IW-1:0]         widx,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [IW-1:0]         ridx,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];
  logic [APB_DATA_W-1:0] mem_d [DEPTH];

  // Next array contents: at most one word replaced per cycle.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[widx] = wdata;
    end else begin
      mem_d[widx] = mem_q[widx];
    end
  end

  // Array storage; reset clears every word.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer: word-addressed register memory with programmable wait states
// and error response for misaligned or out-of-window addresses.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter  logic [APB_ADDR_W-1:0] ADDR_BASE = 32'h0000_0000,
  parameter  int unsigned           DEPTH     = 16,
  parameter  int unsigned           MAX_WAIT  = 15,
  localparam int unsigned           WW        = $clog2(MAX_WAIT + 1)
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_DATA_W-1:0] pwdata,
  input  logic [WW-1:0]         wait_cfg,
  output logic                  pready,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pslverr
);

  localparam int unsigned IW = $clog2(DEPTH);

  apb_slv_state_t        state_q, state_d;
  logic [WW-1:0]         cnt_q, cnt_d;
  logic [APB_ADDR_W-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [APB_DATA_W-1:0] data_q, data_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [APB_DATA_W-1:0] prdata_q, prdata_d;

  logic                  setup_s;
  logic                  enter_resp_s;
  logic                  ok_s;
  logic                  wr_src_s;
  logic                  we_s;
  logic [APB_ADDR_W-1:0] addr_src_s;
  logic [WW-1:0]         wait_sat_s;
  logic [IW-1:0]         idx_s;
  logic [APB_DATA_W-1:0] rdata_s;

  // Saturation only exists when wait_cfg can encode values above MAX_WAIT.
  if (((2 ** WW) - 1) > MAX_WAIT) begin : g_sat
    // Clamp the requested wait count.
    always_comb begin
      if (wait_cfg > WW'(MAX_WAIT)) begin
        wait_sat_s = WW'(MAX_WAIT);
      end else begin
        wait_sat_s = wait_cfg;
      end
    end
  end else begin : g_nosat
    assign wait_sat_s = wait_cfg;
  end

  // Decode source: live bus during setup (zero-wait responds off it), latched copy afterwards.
  always_comb begin
    setup_s = pselx && !penable;
    if (state_q == IDLE) begin
      addr_src_s = paddr;
      wr_src_s   = pwrite;
    end else begin
      addr_src_s = addr_q;
      wr_src_s   = wr_q;
    end
    ok_s  = addr_ok(addr_src_s, ADDR_BASE, DEPTH);
    idx_s = IW'((addr_src_s - ADDR_BASE) >> 2);
    we_s  = (state_q == RESP) && pselx && penable && wr_q && !pslverr_q;
  end

  // Next state, wait counter, setup latches and registered response.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    data_d       = data_q;
    enter_resp_s = 1'b0;
    pready_d     = 1'b0;
    pslverr_d    = 1'b0;
    prdata_d     = '0;

    case (state_q)
      IDLE: begin
        if (setup_s) begin
          addr_d = paddr;
          wr_d   = pwrite;
          data_d = pwdata;
          cnt_d  = wait_sat_s;
          if (wait_sat_s == '0) begin
            state_d      = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!pselx) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= WW'(1)) begin
          state_d      = RESP;
          cnt_d        = '0;
          enter_resp_s = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_q - WW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (enter_resp_s) begin
      pready_d  = 1'b1;
      pslverr_d = !ok_s;
      if (ok_s && !wr_src_s) begin
        prdata_d = rdata_s;
      end else begin
        prdata_d = '0;
      end
    end else begin
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
    end
  end

  // State, latches and output registers; reset abandons any transfer in flight.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  apb_slave_regfile #(
    .DEPTH (DEPTH)
  ) u_regfile (
    .pclk   (pclk),
    .preset (preset),
    .we     (we_s),
    .widx   (idx_s),
    .wdata  (data_q),
    .ridx   (idx_s),
    .rdata  (rdata_s)
  );

  assign pready  = pready_q;
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

endmodule
